// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: flat register numbers, Status/Cause fields, sequencer states.
// Latency: n/a (constants, types and one pure function).
// Backpressure: n/a.
package cp0_pkg;

    localparam logic [5:0] CP0_BADVADDR = 6'd8;
    localparam logic [5:0] CP0_STATUS   = 6'd15;
    localparam logic [5:0] CP0_CAUSE    = 6'd16;
    localparam logic [5:0] CP0_EPC      = 6'd17;
    localparam logic [5:0] CP0_ERROREPC = 6'd37;

    localparam int ST_EXL     = 1;
    localparam int ST_ERL     = 2;
    localparam int ST_BEV     = 22;
    localparam int CA_BD      = 31;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_EXC_HI  = 6;

    localparam logic [31:0] ST_EXL_M = 32'h0000_0002;
    localparam logic [31:0] ST_ERL_M = 32'h0000_0004;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        X_RDST  = 4'd1,
        X_RDCA  = 4'd2,
        X_WEPC  = 4'd3,
        X_WBVA  = 4'd4,
        X_WCA   = 4'd5,
        X_WST   = 4'd6,
        X_REDIR = 4'd7,
        E_RDST  = 4'd8,
        E_RDEPC = 4'd9,
        E_WST   = 4'd10,
        E_REDIR = 4'd11
    } seq_state_t;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] badva;
        logic        badva_vld;
    } exc_cap_t;

    // Optional write states are bypassed here so a skipped state costs no cycle.
    function automatic seq_state_t cp0_next_state(
        input seq_state_t cur,
        input logic       exc_req,
        input logic       eret_req,
        input logic       exl,
        input logic       badva_vld
    );
        seq_state_t nxt;
        nxt = S_IDLE;
        case (cur)
            S_IDLE: begin
                if (exc_req)       nxt = X_RDST;
                else if (eret_req) nxt = E_RDST;
                else               nxt = S_IDLE;
            end
            X_RDST:  nxt = X_RDCA;
            X_RDCA: begin
                if (!exl)          nxt = X_WEPC;
                else if (badva_vld) nxt = X_WBVA;
                else               nxt = X_WCA;
            end
            X_WEPC:  nxt = badva_vld ? X_WBVA : X_WCA;
            X_WBVA:  nxt = X_WCA;
            X_WCA:   nxt = X_WST;
            X_WST:   nxt = X_REDIR;
            X_REDIR: nxt = S_IDLE;
            E_RDST:  nxt = E_RDEPC;
            E_RDEPC: nxt = E_WST;
            E_WST:   nxt = E_REDIR;
            E_REDIR: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cp0_exc_seq.sv
// Exception-entry / ERET sequencer owning the CP0 read and write ports.
// Latency: redirect 4 (ERET) or 5..7 (exception) cycles after the accept edge.
// Backpressure: busy stalls the pipeline; requests are only sampled while idle.
module cp0_exc_seq
    import cp0_pkg::*;
#(
    parameter logic [31:0] RST_VEC_EXC = 32'hBFC0_0380,
    parameter logic [11:0] EXC_OFFSET  = 12'h180
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badva,
    input  logic        exc_badva_vld,
    input  logic        eret_req,
    input  logic [31:0] ebase,
    output logic [5:0]  cp0_rnum,
    input  logic [31:0] cp0_rdata,
    output logic        cp0_we,
    output logic [5:0]  cp0_wnum,
    output logic [31:0] cp0_wdata,
    output logic        busy,
    output logic        redir_vld,
    output logic [31:0] redir_pc
);

    seq_state_t  state;
    seq_state_t  state_nxt;
    exc_cap_t    cap;
    logic [31:0] st;
    logic [31:0] ca;
    logic [31:0] tgt;
    logic [31:0] cause_new;
    logic [31:0] exc_vec;
    logic        ebase_unused;

    assign ebase_unused = ^ebase[11:0];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = cp0_next_state(state, exc_req, eret_req, st[ST_EXL], cap.badva_vld);
    end

    // Request capture and the read half of each read-modify-write.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cap <= '0;
            st  <= '0;
            ca  <= '0;
            tgt <= '0;
        end else begin
            if (state == S_IDLE && exc_req) begin
                cap.code      <= exc_code;
                cap.pc        <= exc_pc;
                cap.bd        <= exc_bd;
                cap.badva     <= exc_badva;
                cap.badva_vld <= exc_badva_vld;
            end
            if (state == X_RDST || state == E_RDST) st  <= cp0_rdata;
            if (state == X_RDCA)                    ca  <= cp0_rdata;
            if (state == E_RDEPC)                   tgt <= cp0_rdata;
        end
    end

    // A nested exception (EXL already set) keeps the original BD bit.
    always_comb begin
        cause_new                      = ca;
        cause_new[CA_EXC_HI:CA_EXC_LO] = cap.code;
        cause_new[CA_BD]               = st[ST_EXL] ? ca[CA_BD] : cap.bd;
    end

    assign exc_vec = st[ST_BEV] ? RST_VEC_EXC : {ebase[31:12], EXC_OFFSET};

    always_comb begin
        busy      = (state != S_IDLE);
        cp0_rnum  = '0;
        cp0_we    = 1'b0;
        cp0_wnum  = '0;
        cp0_wdata = '0;
        redir_vld = 1'b0;
        redir_pc  = '0;
        case (state)
            X_RDST, E_RDST: cp0_rnum = CP0_STATUS;
            X_RDCA:         cp0_rnum = CP0_CAUSE;
            X_WEPC: begin
                cp0_we    = 1'b1;
                cp0_wnum  = CP0_EPC;
                cp0_wdata = cap.pc;
            end
            X_WBVA: begin
                cp0_we    = 1'b1;
                cp0_wnum  = CP0_BADVADDR;
                cp0_wdata = cap.badva;
            end
            X_WCA: begin
                cp0_we    = 1'b1;
                cp0_wnum  = CP0_CAUSE;
                cp0_wdata = cause_new;
            end
            X_WST: begin
                cp0_we    = 1'b1;
                cp0_wnum  = CP0_STATUS;
                cp0_wdata = st | ST_EXL_M;
            end
            X_REDIR: begin
                redir_vld = 1'b1;
                redir_pc  = exc_vec;
            end
            E_RDEPC: cp0_rnum = st[ST_ERL] ? CP0_ERROREPC : CP0_EPC;
            E_WST: begin
                cp0_we    = 1'b1;
                cp0_wnum  = CP0_STATUS;
                cp0_wdata = st[ST_ERL] ? (st & ~ST_ERL_M) : (st & ~ST_EXL_M);
            end
            E_REDIR: begin
                redir_vld = 1'b1;
                redir_pc  = tgt;
            end
            default: ;
        endcase
    end

    a_rw_disjoint: assert property (@(posedge clk) disable iff (!res_n)
        !(cp0_we && cp0_rnum != 6'd0 && cp0_wnum == cp0_rnum));
    a_wr_quiet: assert property (@(posedge clk) disable iff (!res_n)
        !cp0_we |-> (cp0_wnum == 6'd0 && cp0_wdata == 32'd0));
    a_redir_pulse: assert property (@(posedge clk) disable iff (!res_n)
        redir_vld |=> !redir_vld);

endmodule
